// File: rtl/s_mac_quant_if.sv
// s_mac_quant_if: product stream in, requantized result out
interface s_mac_quant_if #(
    parameter int INWL  = 16,
    parameter int OUTWL = 8
);
    logic             valid;
    logic [INWL-1:0]  data;
    logic             clr;
    logic             res_valid;
    logic [OUTWL-1:0] res_data;
    logic             res_sat;
    modport master (output valid, data, clr, input res_valid, res_data, res_sat);
    modport slave  (input valid, data, clr, output res_valid, res_data, res_sat);
endinterface

// File: rtl/s_mac_quant.sv
// s_mac_quant: accumulates ACCN signed products, then rounds half-up and saturates to OUTWL bits
module s_mac_quant #(
    parameter int INWL   = 16,
    parameter int INFWL  = 14,
    parameter int OUTWL  = 8,
    parameter int OUTFWL = 7,
    parameter int CNTWL  = 8,
    parameter int ACCN   = 4
) (
    input logic          clk,
    input logic          rst,
    s_mac_quant_if.slave bus
);
    localparam int SHIFT = INFWL - OUTFWL;
    localparam int ACCWL = INWL + CNTWL;
    localparam logic signed [ACCWL:0] RND  = (ACCWL+1)'(2 ** (SHIFT - 1));
    localparam logic signed [ACCWL:0] MAXV = (ACCWL+1)'(2 ** (OUTWL - 1) - 1);
    localparam logic signed [ACCWL:0] MINV = (ACCWL+1)'(-(2 ** (OUTWL - 1)));
    logic signed [ACCWL-1:0] acc, sum, r_sum;
    logic [CNTWL-1:0]        cnt;
    logic                    done;
    logic signed [ACCWL:0]   ext, rnd;
    logic [OUTWL-1:0]        q_data;
    logic                    q_sat;
    always_comb begin
        sum    = acc + {{CNTWL{bus.data[INWL-1]}}, bus.data};
        ext    = {r_sum[ACCWL-1], r_sum};
        rnd    = (ext + RND) >>> SHIFT;
        q_sat  = (rnd > MAXV) || (rnd < MINV);
        q_data = rnd > MAXV ? {1'b0, {(OUTWL-1){1'b1}}} :
                 rnd < MINV ? {1'b1, {(OUTWL-1){1'b0}}} : rnd[OUTWL-1:0];
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc          <= '0;
            cnt          <= '0;
            r_sum        <= '0;
            done         <= 1'b0;
            bus.res_valid <= 1'b0;
            bus.res_data  <= '0;
            bus.res_sat   <= 1'b0;
        end else begin
            if (bus.clr) begin
                acc  <= '0;
                cnt  <= '0;
                done <= 1'b0;
            end else if (bus.valid) begin
                // last sample of a frame goes straight to r_sum so the next frame starts without a bubble
                if (cnt == CNTWL'(ACCN - 1)) begin
                    r_sum <= sum;
                    acc   <= '0;
                    cnt   <= '0;
                    done  <= 1'b1;
                end else begin
                    acc  <= sum;
                    cnt  <= cnt + 1'b1;
                    done <= 1'b0;
                end
            end else begin
                done <= 1'b0;
            end
            bus.res_valid <= done;
            if (done) begin
                bus.res_data <= q_data;
                bus.res_sat  <= q_sat;
            end
        end
    end
endmodule

// File: tb/tb_s_mac_quant.sv
// tb_s_mac_quant: random and directed stimulus checked against a frame-level arithmetic model
module tb_s_mac_quant;
    localparam int ACCN = 4;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int failures = 0;
    s_mac_quant_if #(.INWL(16), .OUTWL(8)) bus ();
    s_mac_quant #(.INWL(16), .INFWL(14), .OUTWL(8), .OUTFWL(7), .CNTWL(8), .ACCN(ACCN)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );
    always #5 clk = ~clk;

    int frame_sum, frame_cnt;
    bit pend_v, exp_v, pend_s, exp_s;
    int pend_d, exp_d;
    int got_d[$];
    int got_s[$];

    function automatic void quantize(input int s, output int d, output bit sat);
        int x, q;
        x = s + 64;
        q = (x >= 0) ? x / 128 : -((-x + 127) / 128);
        sat = (q > 127) || (q < -128);
        d = q > 127 ? 127 : (q < -128 ? -128 : q);
    endfunction

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_sum = 0; frame_cnt = 0;
            pend_v = 0; pend_d = 0; pend_s = 0;
            exp_v = 0; exp_d = 0; exp_s = 0;
        end else begin
            exp_v = pend_v;
            if (pend_v) begin
                exp_d = pend_d;
                exp_s = pend_s;
            end
            pend_v = 0;
            if (bus.clr) begin
                frame_sum = 0; frame_cnt = 0;
            end else if (bus.valid) begin
                frame_sum += int'($signed(bus.data));
                frame_cnt++;
                if (frame_cnt == ACCN) begin
                    quantize(frame_sum, pend_d, pend_s);
                    pend_v = 1;
                    frame_sum = 0; frame_cnt = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("valid", int'(bus.res_valid), int'(exp_v));
        chk("data", int'($signed(bus.res_data)), exp_d);
        chk("sat", int'(bus.res_sat), int'(exp_s));
        if (bus.res_valid) begin
            got_d.push_back(int'($signed(bus.res_data)));
            got_s.push_back(int'(bus.res_sat));
        end
    end

    task automatic drive(input bit v, input int d, input bit c);
        bus.valid = v;
        bus.data  = 16'(d);
        bus.clr   = c;
        @(negedge clk);
    endtask

    task automatic frame4(input int a, input int b, input int c, input int d);
        drive(1, a, 0); drive(1, b, 0); drive(1, c, 0); drive(1, d, 0);
    endtask

    task automatic expect_results(input string name, input int n, input int d, input bit s);
        repeat (3) drive(0, 0, 0);
        chk({name, "_count"}, got_d.size(), n);
        for (int i = 0; i < got_d.size() && i < n; i++) begin
            chk({name, "_data"}, got_d[i], d);
            chk({name, "_sat"}, got_s[i], int'(s));
        end
        got_d.delete();
        got_s.delete();
    endtask

    initial begin
        bus.valid = 0; bus.data = 0; bus.clr = 0;
        repeat (6) begin
            bus.valid = 1'($urandom); bus.data = 16'($urandom); bus.clr = 1'($urandom);
            @(negedge clk);
        end
        chk("reset_data", int'(bus.res_data), 0);
        chk("reset_valid", int'(bus.res_valid), 0);
        rst = 0;
        drive(0, 0, 0);
        got_d.delete(); got_s.delete();

        frame4(64, 0, 0, 0);          expect_results("round_half_up", 1, 1, 0);
        frame4(-64, 0, 0, 0);         expect_results("round_neg_half", 1, 0, 0);
        frame4(128, 128, 128, 128);   expect_results("sum512", 1, 4, 0);
        frame4(16'h4000, 16'h4000, 16'h4000, 16'h4000); expect_results("sat_pos", 1, 127, 1);
        frame4(16'hC000, 16'hC000, 16'hC000, 16'hC000); expect_results("sat_neg", 1, -128, 1);
        repeat (8) drive(1, 128, 0);  expect_results("b2b", 2, 4, 0);
        repeat (8) begin drive(1, 128, 0); drive(0, 0, 0); end
        expect_results("gaps", 2, 4, 0);
        drive(1, 16'h4000, 0); drive(1, 16'h4000, 0); drive(1, 16'h4000, 1);
        frame4(128, 128, 128, 128);   expect_results("flush", 1, 4, 0);

        drive(1, 300, 0); drive(1, 300, 0); drive(1, 300, 0);
        bus.valid = 0;
        #2 rst = 1;
        #1 chk("async_rst_valid", int'(bus.res_valid), 0);
        chk("async_rst_data", int'(bus.res_data), 0);
        #1 rst = 0;
        @(negedge clk);
        frame4(128, 128, 128, 128);   expect_results("after_rst", 1, 4, 0);

        for (int i = 0; i < 400; i++) begin
            int d;
            d = ($urandom_range(0, 1) == 1) ? int'($urandom) : $urandom_range(0, 600) - 300;
            drive($urandom_range(0, 3) != 0, d, $urandom_range(0, 15) == 0);
        end
        repeat (3) drive(0, 0, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
